// File: rtl/escalonador_comandos_pkg.sv
// Shared definitions for the command scheduler:
// command/response codes, FSM states and response word helpers.
package escalonador_comandos_pkg;

   localparam logic [7:0] CMD_STATUS = 8'h01;
   localparam logic [7:0] CMD_TEMP   = 8'h02;
   localparam logic [7:0] CMD_UMID   = 8'h03;
   localparam logic [7:0] CMD_CT_ON  = 8'h04;
   localparam logic [7:0] CMD_CU_ON  = 8'h05;
   localparam logic [7:0] CMD_CT_OFF = 8'h06;
   localparam logic [7:0] CMD_CU_OFF = 8'h07;

   localparam logic [7:0] RSP_OK     = 8'h07;
   localparam logic [7:0] RSP_UMID   = 8'h08;
   localparam logic [7:0] RSP_TEMP   = 8'h09;
   localparam logic [7:0] RSP_CT_OFF = 8'h0A;
   localparam logic [7:0] RSP_CU_OFF = 8'h0B;
   localparam logic [7:0] RSP_FALHA  = 8'h1F;
   localparam logic [7:0] RSP_INVAL  = 8'hCF;
   localparam logic [7:0] RSP_END    = 8'hEF;

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      DECODIFICA    = 3'd1,
      REQ_SENSOR    = 3'd2,
      ESPERA_SENSOR = 3'd3,
      CARREGA_TX    = 3'd4,
      ESPERA_TX     = 3'd5
   } estado_t;

   typedef enum logic [1:0] {
      LE_STATUS = 2'd0,
      LE_TEMP   = 2'd1,
      LE_UMID   = 2'd2
   } leitura_t;

   function automatic logic [15:0] palavra(
      input logic [7:0] codigo,
      input logic [7:0] dado
   );
      return {codigo, dado};
   endfunction

   function automatic logic cmd_valido(input logic [7:0] c);
      return (c >= CMD_STATUS) && (c <= CMD_CU_OFF);
   endfunction

endpackage

// File: rtl/escalonador_comandos_contador_timeout.sv
// Saturating down-counter: load has priority, expirou while at zero.
// Used for the sensor timeout and the continuous-mode period.
module contador_timeout #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         carrega,
   input  logic         habilita,
   input  logic [W-1:0] valor,
   output logic         expirou
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (carrega)
         cnt_d = valor;
      else if (habilita && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expirou = (cnt_q == '0);

endmodule

// File: rtl/escalonador_comandos.sv
// Host command scheduler: decodes UART words, drives one sensor read
// per command, replies through the transmitter, runs periodic reads.
module escalonador_comandos
   import escalonador_comandos_pkg::*;
#(
   parameter int NUM_SENSORES   = 32,
   parameter int TIMEOUT_CICLOS = 100000,
   parameter int PERIODO_CICLOS = 50000000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_valid,
   input  logic [15:0] rx_word,
   output logic        sensor_req,
   output logic [7:0]  sensor_addr,
   input  logic        sensor_done,
   input  logic        sensor_err,
   input  logic [7:0]  sensor_temp,
   input  logic [7:0]  sensor_umid,
   output logic        tx_start,
   output logic [15:0] tx_word,
   input  logic        tx_done,
   output logic        ocupado,
   output logic        overflow
);

   localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
   localparam int PW = $clog2(PERIODO_CICLOS + 1);
   // Loads chosen so tx_start lands exactly TIMEOUT_CICLOS after
   // sensor_req, and idle periodic reads are PERIODO_CICLOS apart.
   localparam logic [TW-1:0] TO_CARGA  = TW'(TIMEOUT_CICLOS - 2);
   localparam logic [PW-1:0] PER_CARGA = PW'(PERIODO_CICLOS - 1);
   localparam logic [8:0]    NUM_S     = 9'(NUM_SENSORES);

   estado_t     estado_q, estado_d;
   logic [15:0] buf_q, buf_d;
   logic        cheio_q, cheio_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  addr_q, addr_d;
   leitura_t    leit_q, leit_d;
   logic [15:0] resp_q, resp_d;
   logic        ct_q, ct_d;
   logic        cu_q, cu_d;
   logic [7:0]  caddr_q, caddr_d;
   logic        alt_q, alt_d;

   logic        libera;
   logic        per_carrega;
   logic        per_hab;
   logic        per_exp;
   logic        to_carrega;
   logic        to_hab;
   logic        to_exp;
   logic [7:0]  cmd;
   logic [7:0]  ender;
   logic        end_ok;
   logic        c_inval;
   logic        c_end;
   logic        c_ct_off;
   logic        c_cu_off;

   assign cmd      = buf_q[7:0];
   assign ender    = buf_q[15:8];
   assign end_ok   = ({1'b0, ender} < NUM_S);
   assign c_inval  = !cmd_valido(cmd);
   assign c_end    = cmd_valido(cmd) && !end_ok;
   assign c_ct_off = end_ok && (cmd == CMD_CT_OFF);
   assign c_cu_off = end_ok && (cmd == CMD_CU_OFF);

   assign to_carrega = (estado_q == REQ_SENSOR);
   assign to_hab     = (estado_q == ESPERA_SENSOR);
   assign per_hab    = ct_q | cu_q;

   contador_timeout #(.W(TW)) u_timeout (
      .clock    (clock),
      .reset_n  (reset_n),
      .carrega  (to_carrega),
      .habilita (to_hab),
      .valor    (TO_CARGA),
      .expirou  (to_exp)
   );

   contador_timeout #(.W(PW)) u_periodo (
      .clock    (clock),
      .reset_n  (reset_n),
      .carrega  (per_carrega),
      .habilita (per_hab),
      .valor    (PER_CARGA),
      .expirou  (per_exp)
   );

   always_comb begin
      estado_d    = estado_q;
      addr_d      = addr_q;
      leit_d      = leit_q;
      resp_d      = resp_q;
      ct_d        = ct_q;
      cu_d        = cu_q;
      caddr_d     = caddr_q;
      alt_d       = alt_q;
      libera      = 1'b0;
      per_carrega = 1'b0;

      unique case (estado_q)
         OCIOSO: begin
            if (cheio_q) begin
               estado_d = DECODIFICA;
            end else if (per_hab && per_exp) begin
               estado_d    = REQ_SENSOR;
               addr_d      = caddr_q;
               per_carrega = 1'b1;
               if (ct_q && cu_q) begin
                  leit_d = alt_q ? LE_UMID : LE_TEMP;
                  alt_d  = ~alt_q;
               end else begin
                  leit_d = ct_q ? LE_TEMP : LE_UMID;
               end
            end
         end
         DECODIFICA: begin
            libera   = 1'b1;
            estado_d = CARREGA_TX;
            unique case (1'b1)
               c_inval:  resp_d = palavra(RSP_INVAL, 8'h00);
               c_end:    resp_d = palavra(RSP_END, 8'h00);
               c_ct_off: begin
                  ct_d   = 1'b0;
                  resp_d = palavra(RSP_CT_OFF, 8'h00);
               end
               c_cu_off: begin
                  cu_d   = 1'b0;
                  resp_d = palavra(RSP_CU_OFF, 8'h00);
               end
               default: begin
                  estado_d = REQ_SENSOR;
                  addr_d   = ender;
                  if (cmd == CMD_STATUS)
                     leit_d = LE_STATUS;
                  else if ((cmd == CMD_TEMP) || (cmd == CMD_CT_ON))
                     leit_d = LE_TEMP;
                  else
                     leit_d = LE_UMID;
                  if (cmd == CMD_CT_ON) begin
                     ct_d        = 1'b1;
                     caddr_d     = ender;
                     per_carrega = 1'b1;
                  end
                  if (cmd == CMD_CU_ON) begin
                     cu_d        = 1'b1;
                     caddr_d     = ender;
                     per_carrega = 1'b1;
                  end
               end
            endcase
         end
         REQ_SENSOR: estado_d = ESPERA_SENSOR;
         ESPERA_SENSOR: begin
            if (sensor_done) begin
               estado_d = CARREGA_TX;
               if (sensor_err)
                  resp_d = palavra(RSP_FALHA, 8'h00);
               else begin
                  case (leit_q)
                     LE_STATUS: resp_d = palavra(RSP_OK, 8'h00);
                     LE_TEMP:   resp_d = palavra(RSP_TEMP, sensor_temp);
                     default:   resp_d = palavra(RSP_UMID, sensor_umid);
                  endcase
               end
            end else if (to_exp) begin
               estado_d = CARREGA_TX;
               resp_d   = palavra(RSP_FALHA, 8'h00);
            end
         end
         CARREGA_TX: estado_d = ESPERA_TX;
         ESPERA_TX: begin
            if (tx_done)
               estado_d = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // Pending buffer: a word arriving on the freeing cycle is kept.
   always_comb begin
      buf_d   = buf_q;
      cheio_d = cheio_q;
      ovf_d   = 1'b0;
      if (rx_valid) begin
         if (!cheio_q || libera) begin
            buf_d   = rx_word;
            cheio_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (libera) begin
         cheio_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= OCIOSO;
         buf_q    <= '0;
         cheio_q  <= 1'b0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         leit_q   <= LE_STATUS;
         resp_q   <= '0;
         ct_q     <= 1'b0;
         cu_q     <= 1'b0;
         caddr_q  <= '0;
         alt_q    <= 1'b0;
      end else begin
         estado_q <= estado_d;
         buf_q    <= buf_d;
         cheio_q  <= cheio_d;
         ovf_q    <= ovf_d;
         addr_q   <= addr_d;
         leit_q   <= leit_d;
         resp_q   <= resp_d;
         ct_q     <= ct_d;
         cu_q     <= cu_d;
         caddr_q  <= caddr_d;
         alt_q    <= alt_d;
      end
   end

   assign sensor_req  = (estado_q == REQ_SENSOR);
   assign sensor_addr = addr_q;
   assign tx_start    = (estado_q == CARREGA_TX);
   assign tx_word     = resp_q;
   assign ocupado     = (estado_q != OCIOSO);
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_escalonador_comandos.sv
// Directed bench for escalonador_comandos: hand-computed responses,
// latencies, timeout, periodic reads, overflow and async reset.
module tb_escalonador_comandos;

   localparam int TO  = 200;
   localparam int PER = 1000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        rx_valid;
   logic [15:0] rx_word;
   logic        sensor_req;
   logic [7:0]  sensor_addr;
   logic        sensor_done;
   logic        sensor_err;
   logic [7:0]  sensor_temp;
   logic [7:0]  sensor_umid;
   logic        tx_start;
   logic [15:0] tx_word;
   logic        tx_done;
   logic        ocupado;
   logic        overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int nreq  = 0;
   int ntx   = 0;
   int novf  = 0;
   int req_cyc = 0;
   int tx_cyc  = 0;
   logic [7:0]  req_addr = '0;
   logic [15:0] tx_w = '0;

   escalonador_comandos #(
      .NUM_SENSORES   (32),
      .TIMEOUT_CICLOS (TO),
      .PERIODO_CICLOS (PER)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .rx_valid    (rx_valid),
      .rx_word     (rx_word),
      .sensor_req  (sensor_req),
      .sensor_addr (sensor_addr),
      .sensor_done (sensor_done),
      .sensor_err  (sensor_err),
      .sensor_temp (sensor_temp),
      .sensor_umid (sensor_umid),
      .tx_start    (tx_start),
      .tx_word     (tx_word),
      .tx_done     (tx_done),
      .ocupado     (ocupado),
      .overflow    (overflow)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (sensor_req) begin
         nreq     <= nreq + 1;
         req_cyc  <= cyc;
         req_addr <= sensor_addr;
      end
      if (tx_start) begin
         ntx    <= ntx + 1;
         tx_cyc <= cyc;
         tx_w   <= tx_word;
      end
      if (overflow) novf <= novf + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clock);
      #1;
   endtask

   task automatic send(input logic [15:0] w, output int c);
      tick;
      rx_valid = 1'b1;
      rx_word  = w;
      c        = cyc;
      tick;
      rx_valid = 1'b0;
   endtask

   task automatic sresp(input logic e, input logic [7:0] t,
                        input logic [7:0] u);
      tick;
      sensor_done = 1'b1;
      sensor_err  = e;
      sensor_temp = t;
      sensor_umid = u;
      tick;
      sensor_done = 1'b0;
      sensor_err  = 1'b0;
   endtask

   task automatic txd;
      tick;
      tx_done = 1'b1;
      tick;
      tx_done = 1'b0;
   endtask

   task automatic wait_req(input int alvo, input int lim, input string tag);
      int k;
      k = 0;
      while (nreq < alvo && k < lim) begin
         tick;
         k++;
      end
      chk(tag, 32'(nreq >= alvo), 1);
   endtask

   task automatic wait_tx(input int alvo, input int lim, input string tag);
      int k;
      k = 0;
      while (ntx < alvo && k < lim) begin
         tick;
         k++;
      end
      chk(tag, 32'(ntx >= alvo), 1);
   endtask

   initial begin
      int c0;
      int rc;
      int r0;
      int r1;
      int n;
      int o0;
      int k;

      reset_n     = 1'b0;
      rx_valid    = 1'b0;
      rx_word     = '0;
      sensor_done = 1'b0;
      sensor_err  = 1'b0;
      sensor_temp = '0;
      sensor_umid = '0;
      tx_done     = 1'b0;
      repeat (3) tick;
      chk("reset_outs", {sensor_req, tx_start, ocupado, overflow,
                         sensor_addr, tx_word}, 0);
      reset_n = 1'b1;
      tick;

      // T1: temp read of addr 05
      n = nreq;
      send(16'h0502, c0);
      wait_req(n + 1, 20, "t1_req_seen");
      chk("t1_req_lat", 32'(req_cyc - c0), 3);
      chk("t1_addr", req_addr, 8'h05);
      repeat (3) tick;
      n = ntx;
      sresp(1'b0, 8'h19, 8'h44);
      wait_tx(n + 1, 20, "t1_tx_seen");
      chk("t1_word", tx_w, 16'h0919);
      tick;
      chk("t1_hold", {ocupado, tx_word}, {1'b1, 16'h0919});
      txd;
      chk("t1_idle", ocupado, 1'b0);

      // T2: invalid command
      n = ntx;
      r0 = nreq;
      send(16'h0099, c0);
      wait_tx(n + 1, 20, "t2_tx_seen");
      chk("t2_lat", 32'(tx_cyc - c0), 3);
      chk("t2_word", tx_w, 16'hCF00);
      chk("t2_noreq", nreq, r0);
      txd;

      // T2b: address out of range
      n = ntx;
      send(16'h2802, c0);
      wait_tx(n + 1, 20, "t2b_tx_seen");
      chk("t2b_word", tx_w, 16'hEF00);
      chk("t2b_noreq", nreq, r0);
      txd;

      // sensor fault on status read
      n = nreq;
      send(16'h0401, c0);
      wait_req(n + 1, 20, "err_req_seen");
      n = ntx;
      sresp(1'b1, 8'h77, 8'h88);
      wait_tx(n + 1, 20, "err_tx_seen");
      chk("err_word", tx_w, 16'h1F00);
      txd;

      // T3: timeout, late done ignored
      n = nreq;
      send(16'h0302, c0);
      wait_req(n + 1, 20, "t3_req_seen");
      rc = req_cyc;
      n = ntx;
      wait_tx(n + 1, TO + 20, "t3_tx_seen");
      chk("t3_lat", 32'(tx_cyc - rc), TO);
      chk("t3_word", tx_w, 16'h1F00);
      sresp(1'b0, 8'h55, 8'h66);
      chk("t3_late_hold", tx_word, 16'h1F00);
      txd;
      n = ntx;
      sresp(1'b0, 8'h55, 8'h66);
      repeat (5) tick;
      chk("t3_idle_notx", ntx, n);
      chk("t3_idle", ocupado, 1'b0);

      // done on the expiry cycle beats the timeout
      n = nreq;
      send(16'h0702, c0);
      wait_req(n + 1, 20, "t3b_req_seen");
      rc = req_cyc;
      k = 0;
      while (cyc < rc + TO - 1 && k < TO + 10) begin
         tick;
         k++;
      end
      n = ntx;
      sensor_done = 1'b1;
      sensor_temp = 8'h44;
      tick;
      sensor_done = 1'b0;
      wait_tx(n + 1, 20, "t3b_tx_seen");
      chk("t3b_word", tx_w, 16'h0944);
      chk("t3b_lat", 32'(tx_cyc - rc), TO);
      txd;

      // T4: continuous temp on addr 03
      n = nreq;
      send(16'h0304, c0);
      wait_req(n + 1, 20, "t4_req0_seen");
      chk("t4_addr0", req_addr, 8'h03);
      r0 = req_cyc;
      n = ntx;
      sresp(1'b0, 8'h20, 8'h00);
      wait_tx(n + 1, 20, "t4_tx0_seen");
      chk("t4_word0", tx_w, 16'h0920);
      txd;
      n = nreq;
      wait_req(n + 1, PER + 200, "t4_req1_seen");
      chk("t4_addr1", req_addr, 8'h03);
      chk("t4_per1", 32'((req_cyc - r0 >= PER - 10) &&
                         (req_cyc - r0 <= PER + 10)), 1);
      r1 = req_cyc;
      n = ntx;
      sresp(1'b0, 8'h21, 8'h00);
      wait_tx(n + 1, 20, "t4_tx1_seen");
      chk("t4_word1", tx_w, 16'h0921);
      txd;
      repeat (300) tick;
      n = nreq;
      send(16'h0101, c0);
      wait_req(n + 1, 20, "t4_cmd_req_seen");
      chk("t4_cmd_lat", 32'(req_cyc - c0), 3);
      chk("t4_cmd_addr", req_addr, 8'h01);
      n = ntx;
      sresp(1'b0, 8'h00, 8'h00);
      wait_tx(n + 1, 20, "t4_cmd_tx_seen");
      chk("t4_cmd_word", tx_w, 16'h0700);
      txd;
      n = nreq;
      wait_req(n + 1, PER + 200, "t4_req2_seen");
      chk("t4_addr2", req_addr, 8'h03);
      chk("t4_per2", 32'((req_cyc - r1 >= PER - 10) &&
                         (req_cyc - r1 <= PER + 10)), 1);
      n = ntx;
      sresp(1'b0, 8'h22, 8'h00);
      wait_tx(n + 1, 20, "t4_tx2_seen");
      chk("t4_word2", tx_w, 16'h0922);
      txd;
      n = ntx;
      send(16'h0306, c0);
      wait_tx(n + 1, 20, "t4_off_seen");
      chk("t4_off_word", tx_w, 16'h0A00);
      chk("t4_off_lat", 32'(tx_cyc - c0), 3);
      txd;
      n = nreq;
      repeat (2 * PER + 500) tick;
      chk("t4_stopped", nreq, n);

      // T5: second buffered, third dropped
      o0 = novf;
      n = nreq;
      send(16'h0102, c0);
      wait_req(n + 1, 20, "t5_req0_seen");
      send(16'h0201, c0);
      send(16'h0403, c0);
      tick;
      chk("t5_ovf", novf - o0, 1);
      n = ntx;
      sresp(1'b0, 8'h11, 8'h00);
      wait_tx(n + 1, 20, "t5_tx0_seen");
      chk("t5_word0", tx_w, 16'h0911);
      n = nreq;
      txd;
      wait_req(n + 1, 20, "t5_req1_seen");
      chk("t5_addr1", req_addr, 8'h02);
      n = ntx;
      sresp(1'b0, 8'h00, 8'h00);
      wait_tx(n + 1, 20, "t5_tx1_seen");
      chk("t5_word1", tx_w, 16'h0700);
      txd;
      n = nreq;
      repeat (30) tick;
      chk("t5_third_dropped", nreq, n);
      chk("t5_ovf_once", novf - o0, 1);

      // T6: async reset during sensor wait
      n = nreq;
      send(16'h0602, c0);
      wait_req(n + 1, 20, "t6_req_seen");
      tick;
      tick;
      chk("t6_busy", ocupado, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_outs", {sensor_req, tx_start, ocupado, overflow,
                          sensor_addr, tx_word}, 0);
      tick;
      reset_n = 1'b1;
      tick;
      n = ntx;
      sresp(1'b0, 8'h33, 8'h00);
      repeat (10) tick;
      chk("t6_no_tx", ntx, n);
      chk("t6_idle", ocupado, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
